// File: rtl/lsu_sram_bridge_if.sv
// Request/response/SRAM bundle for the load/store bridge.
// The bridge connects through the slave modport; the core and the SRAM
// model on the other side use the master modport.
interface lsu_sram_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [1:0]        req_size;
  logic              req_sext;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic              sram_en;
  logic [3:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport slave (
    input  req_valid, req_wr, req_size, req_sext, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output req_valid, req_wr, req_size, req_sext, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/lsu_sram_bridge.sv
// Load/store bridge between the core's MEM stage and the data SRAM.
// One request in, one SRAM access, one response out; stores build byte
// strobes and replicate data across lanes, loads wait RD_LAT cycles and
// then pick/extend the addressed lane.
// Optional build macro MISALIGN_CHECK_EN: misaligned half/word requests
// skip the SRAM entirely and answer with resp_err=1.
module lsu_sram_bridge #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input logic            clk,
  input logic            reset,
  lsu_sram_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic              wr_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        cnt_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              misaligned;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_ext;
  logic [3:0]        store_we;
  logic [31:0]       store_data;

  // ready is gated by reset so nothing can be accepted during a reset cycle
  assign bus.req_ready = (state == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

`ifdef MISALIGN_CHECK_EN
  assign misaligned = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state and state-decoded outputs
  always_comb begin
    state_nxt      = state;
    bus.sram_en    = 1'b0;
    bus.sram_we    = 4'b0000;
    bus.sram_wdata = 32'h0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = misaligned ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.sram_en = 1'b1;
        if (wr_q) begin
          bus.sram_we    = store_we;
          bus.sram_wdata = store_data;
        end
        state_nxt = wr_q ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.sram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // store strobes and lane-replicated store data from the latched request
  always_comb begin
    store_we   = 4'hF;
    store_data = wdata_q;
    case (size_q)
      2'd0: begin
        store_we   = 4'b0001 << addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        store_we   = 4'b0011 << {addr_q[1], 1'b0};
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        store_we   = 4'hF;
        store_data = wdata_q;
      end
    endcase
  end

  // load lane selection and sign/zero extension of the SRAM word
  always_comb begin
    load_byte = bus.sram_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    load_byte = bus.sram_rdata[7:0];
      2'd1:    load_byte = bus.sram_rdata[15:8];
      2'd2:    load_byte = bus.sram_rdata[23:16];
      default: load_byte = bus.sram_rdata[31:24];
    endcase
    load_half = addr_q[1] ? bus.sram_rdata[31:16] : bus.sram_rdata[15:0];
    case (size_q)
      2'd0:    load_ext = {{24{sext_q & load_byte[7]}}, load_byte};
      2'd1:    load_ext = {{16{sext_q & load_half[15]}}, load_half};
      default: load_ext = bus.sram_rdata;
    endcase
  end

  // request latch, read-latency counter and held response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      cnt_q   <= 2'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wr_q    <= bus.req_wr;
        size_q  <= bus.req_size;
        sext_q  <= bus.req_sext;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= 32'h0;
        err_q   <= misaligned;
      end
      if (state == ACCESS) begin
        cnt_q <= 2'(RD_LAT - 1);
      end else if (state == WAIT) begin
        cnt_q <= cnt_q - 2'd1;
        if (cnt_q == 2'd0) rdata_q <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// Self-checking bench for lsu_sram_bridge: reset state, a table of directed
// requests, randomized requests against a reference model, reset during a
// load, and a second instance with RD_LAT=3 for the latency corner.
module tb_lsu_sram_bridge;

  localparam int RD_LAT = 1;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          hold;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lsu_sram_bridge_if #(.ADDR_W(32)) bus ();
  lsu_sram_bridge_if #(.ADDR_W(32)) bus3 ();

  lsu_sram_bridge #(.RD_LAT(RD_LAT), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  lsu_sram_bridge #(.RD_LAT(3), .ADDR_W(32)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // reference model: derives expectations from the address offset and the
  // access width in bytes using plain arithmetic
  function automatic vec_t model(input logic wr, input logic [1:0] size,
                                 input logic sext, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int hold);
    vec_t   v;
    int     off, nb, lane;
    longint val, mask;
    bit     mis;
    v.wr = wr; v.size = size; v.sext = sext; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.hold = hold;
    off  = int'(addr % 4);
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    lane = off - (off % nb);
    mask = (64'd1 << (8 * nb)) - 1;
    mis  = 1'b0;
`ifdef MISALIGN_CHECK_EN
    mis = (off % nb) != 0;
`endif
    v.exp_we = 4'h0; v.exp_wdata = 32'h0; v.exp_rdata = 32'h0; v.exp_err = 1'b0;
    if (mis) begin
      v.exp_err = 1'b1;
      v.exp_lat = 1;
    end else if (wr) begin
      v.exp_we    = 4'(((1 << nb) - 1) << lane);
      v.exp_wdata = 32'((longint'(wdata) & mask) *
                        ((nb == 1) ? 64'h01010101 : (nb == 2) ? 64'h00010001 : 64'h1));
      v.exp_lat   = 2;
    end else begin
      val = (longint'(rdata) >> (8 * lane)) & mask;
      if (sext && nb < 4 && val >= (mask + 1) / 2) val = val - (mask + 1);
      v.exp_rdata = 32'(val);
      v.exp_lat   = 2 + RD_LAT;
    end
    return v;
  endfunction

  // drives one request through the RD_LAT=1 instance, acting as the SRAM
  // (read data valid only RD_LAT cycles after the enable cycle) and checking
  // strobes, latency, response contents and backpressure behaviour
  task automatic applyStimulus(input vec_t v);
    int          lat;
    int          c;
    logic [31:0] got_rdata;
    logic        got_err;
    c = 0;
    while (!bus.req_ready && c < 20) begin
      step();
      c++;
    end
    checkOutput("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_wr     = v.wr;
    bus.req_size   = v.size;
    bus.req_sext   = v.sext;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.resp_ready = 1'b0;
    bus.sram_rdata = $urandom;
    step();
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'($urandom);
    bus.req_size  = 2'($urandom);
    bus.req_sext  = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    for (lat = 1; lat <= 20; lat++) begin
      bus.sram_rdata = (lat == 1 + RD_LAT) ? v.rdata : $urandom;
      if (lat == 1) begin
        checkOutput("sram_en", 32'(bus.sram_en), 32'(v.exp_lat > 1));
        checkOutput("sram_we", 32'(bus.sram_we), 32'(v.exp_we));
        checkOutput("sram_addr", bus.sram_addr, v.addr & 32'hFFFF_FFFC);
        if (v.wr) checkOutput("sram_wdata", bus.sram_wdata, v.exp_wdata);
      end else begin
        checkOutput("sram_en_idle", 32'(bus.sram_en), 32'd0);
      end
      if (bus.resp_valid) break;
      step();
    end
    checkOutput("resp_latency", 32'(lat), 32'(v.exp_lat));
    if (lat > 20) return;
    got_rdata = bus.resp_rdata;
    got_err   = bus.resp_err;
    checkOutput("resp_rdata", got_rdata, v.exp_rdata);
    checkOutput("resp_err", 32'(got_err), 32'(v.exp_err));
    checkOutput("req_ready_busy", 32'(bus.req_ready), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      step();
      bus.sram_rdata = $urandom;
      checkOutput("hold_valid", 32'(bus.resp_valid), 32'd1);
      checkOutput("hold_rdata", bus.resp_rdata, got_rdata);
      checkOutput("hold_err", 32'(bus.resp_err), 32'(got_err));
      checkOutput("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    checkOutput("resp_valid_after", 32'(bus.resp_valid), 32'd0);
    checkOutput("req_ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    vec_t v;
    int   lat;

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'd0; bus.req_sext = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0; bus.sram_rdata = 32'h0;
    bus3.req_valid = 1'b0; bus3.req_wr = 1'b0; bus3.req_size = 2'd0; bus3.req_sext = 1'b0;
    bus3.req_addr = 32'h0; bus3.req_wdata = 32'h0; bus3.resp_ready = 1'b0; bus3.sram_rdata = 32'h0;

    // wr, size, sext, addr, wdata, rdata, exp_we, exp_wdata, exp_rdata, exp_err, exp_lat, hold
    vecs[0] = '{1'b1, 2'd2, 1'b0, 32'h1C000004, 32'hDEADBEEF, 32'h0,
                4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0};
    vecs[1] = '{1'b1, 2'd0, 1'b0, 32'h1C000003, 32'h000000A5, 32'h0,
                4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0, 2, 1};
    vecs[2] = '{1'b0, 2'd0, 1'b1, 32'h1C000001, 32'h0, 32'h123480FF,
                4'h0, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0};
    vecs[3] = '{1'b0, 2'd0, 1'b0, 32'h1C000001, 32'h0, 32'h123480FF,
                4'h0, 32'h0, 32'h00000080, 1'b0, 3, 0};
    vecs[4] = '{1'b0, 2'd1, 1'b1, 32'h1C000002, 32'h0, 32'h80010000,
                4'h0, 32'h0, 32'hFFFF8001, 1'b0, 3, 5};
`ifdef MISALIGN_CHECK_EN
    vecs[5] = '{1'b0, 2'd2, 1'b0, 32'h1C000002, 32'h0, 32'hCAFEF00D,
                4'h0, 32'h0, 32'h0, 1'b1, 1, 0};
`else
    vecs[5] = '{1'b0, 2'd2, 1'b0, 32'h1C000002, 32'h0, 32'hCAFEF00D,
                4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 3, 0};
`endif
    vecs[6] = '{1'b1, 2'd1, 1'b0, 32'h1C000006, 32'h1234BEEF, 32'h0,
                4'hC, 32'hBEEFBEEF, 32'h0, 1'b0, 2, 0};
    vecs[7] = '{1'b0, 2'd1, 1'b0, 32'h1C000000, 32'h0, 32'h1234F00D,
                4'h0, 32'h0, 32'h0000F00D, 1'b0, 3, 2};
    vecs[8] = '{1'b0, 2'd3, 1'b1, 32'h1C000008, 32'h0, 32'h80000001,
                4'h0, 32'h0, 32'h80000001, 1'b0, 3, 0};
    vecs[9] = '{1'b1, 2'd0, 1'b0, 32'h1C000000, 32'hFFFFFF5A, 32'h0,
                4'b0001, 32'h5A5A5A5A, 32'h0, 1'b0, 2, 0};

    step(); step(); step();
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("rst_resp_err", 32'(bus.resp_err), 32'd0);
    checkOutput("rst_sram_en", 32'(bus.sram_en), 32'd0);
    checkOutput("rst_sram_we", 32'(bus.sram_we), 32'd0);
    reset = 1'b0;
    step();

    $display("[TB] directed vectors");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    $display("[TB] randomized requests");
    for (int i = 0; i < 150; i++) begin
      v = model(1'($urandom), 2'($urandom), 1'($urandom),
                32'h1C000000 | 32'($urandom_range(0, 255)),
                $urandom, $urandom, $urandom_range(0, 3));
      applyStimulus(v);
    end

    $display("[TB] reset during load wait");
    checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_size = 2'd2; bus.req_sext = 1'b0;
    bus.req_addr = 32'h1C000010; bus.resp_ready = 1'b1;
    step();
    bus.req_valid = 1'b0;
    checkOutput("mid_rst_access", 32'(bus.sram_en), 32'd1);
    step();
    bus.sram_rdata = 32'h55AA55AA;
    reset = 1'b1;
    step();
    checkOutput("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("mid_rst_sram_en", 32'(bus.sram_en), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checkOutput("post_rst_no_resp", 32'(bus.resp_valid), 32'd0);
      checkOutput("post_rst_no_en", 32'(bus.sram_en), 32'd0);
    end
    bus.resp_ready = 1'b0;
    applyStimulus(vecs[2]);

    $display("[TB] RD_LAT=3 byte load");
    checkOutput("lat3_req_ready", 32'(bus3.req_ready), 32'd1);
    bus3.req_valid = 1'b1; bus3.req_wr = 1'b0; bus3.req_size = 2'd0; bus3.req_sext = 1'b1;
    bus3.req_addr = 32'h1C000001; bus3.resp_ready = 1'b0;
    step();
    bus3.req_valid = 1'b0;
    for (lat = 1; lat <= 20; lat++) begin
      bus3.sram_rdata = (lat == 4) ? 32'h123480FF : $urandom;
      if (bus3.resp_valid) break;
      step();
    end
    checkOutput("lat3_latency", 32'(lat), 32'd5);
    checkOutput("lat3_rdata", bus3.resp_rdata, 32'hFFFFFF80);
    bus3.resp_ready = 1'b1;
    step();
    bus3.resp_ready = 1'b0;
    checkOutput("lat3_resp_done", 32'(bus3.resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
